// File: rtl/irq_collector.sv
// Interrupt collector: synchronises sources, latches edge/level pending state and
// presents the lowest-index eligible source to the core through a claim/complete handshake.
module irq_collector #(
    parameter int NUM_IRQ     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic [NUM_IRQ-1:0] edge_mode_i,
    input  logic [NUM_IRQ-1:0] mask_i,
    input  logic               claim_i,
    input  logic               complete_i,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic               busy_o,
    output logic [NUM_IRQ-1:0] pending_o
);

    // state   | meaning
    // IDLE    | nothing presented, arbitrate eligible sources
    // ASSERT  | r_id presented to core, waiting for claim
    // SERVICE | r_id claimed, waiting for complete
    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} state_t;

    logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_pending;
    state_t             r_state;
    logic [ID_W-1:0]    r_id;
    logic               r_irq;
    logic               r_busy;

    logic [NUM_IRQ-1:0] w_sync;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_clear;
    logic [ID_W-1:0]    w_winner;
    logic               w_any;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_eligible = r_pending & mask_i;
    assign w_any      = |w_eligible;

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) w_winner = ID_W'(i);
        end
    end

    always_comb begin
        w_clear = '0;
        if (r_state == ST_ASSERT && claim_i && edge_mode_i[r_id]) w_clear[r_id] = 1'b1;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_sync[0] <= irq_src_i;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_prev    <= w_sync;
            // A new edge outranks a claim-clear on the same bit.
            r_pending <= (edge_mode_i & ((r_pending & ~w_clear) | (w_sync & ~r_prev)))
                       | (~edge_mode_i & w_sync);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_ASSERT;
                        r_id    <= w_winner;
                        r_irq   <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (claim_i) begin
                        r_state <= ST_SERVICE;
                        r_irq   <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (!w_eligible[r_id]) begin
                        r_state <= ST_IDLE;
                        r_irq   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (complete_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_irq   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o     = r_irq;
    assign irq_id_o  = r_id;
    assign busy_o    = r_busy;
    assign pending_o = r_pending;

endmodule

// File: tb/tb_irq_collector.sv
// Bench for irq_collector: directed latency/reset cases plus randomized traffic,
// checked every cycle against a queue-fed reference model.
module tb_irq_collector;

    localparam int N   = 3;
    localparam int SS  = 2;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   src, emode, mask;
    logic           claim, complete;
    logic           irq;
    logic [IDW-1:0] id;
    logic           busy;
    logic [N-1:0]   pend;

    always #5 clk = ~clk;

    irq_collector #(.NUM_IRQ(N), .SYNC_STAGES(SS)) dut (
        .clock_i(clk), .reset_i(rst), .irq_src_i(src), .edge_mode_i(emode),
        .mask_i(mask), .claim_i(claim), .complete_i(complete),
        .irq_o(irq), .irq_id_o(id), .busy_o(busy), .pending_o(pend)
    );

    typedef struct packed {
        logic           irq;
        logic [IDW-1:0] id;
        logic           busy;
        logic [N-1:0]   pend;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: delay line of raw samples, pending set, and a phase
    // (0 = nothing presented, 1 = presenting, 2 = in service).
    logic [N-1:0] m_line[$];
    logic [N-1:0] m_prev, m_pend;
    int           m_phase, m_id;

    function automatic void model_reset();
        m_line = {};
        for (int k = 0; k < SS; k++) m_line.push_back('0);
        m_prev  = '0;
        m_pend  = '0;
        m_phase = 0;
        m_id    = 0;
    endfunction

    function automatic void model_edge();
        logic [N-1:0] s, elig, nxt;
        obs_t e;
        if (rst) begin
            model_reset();
        end else begin
            s    = m_line[SS-1];
            elig = m_pend & mask;
            for (int i = 0; i < N; i++) begin
                if (emode[i])
                    nxt[i] = (m_pend[i] && !(m_phase == 1 && claim && m_id == i))
                             || (s[i] && !m_prev[i]);
                else
                    nxt[i] = s[i];
            end
            if (m_phase == 0) begin
                if (elig != 0) begin
                    m_phase = 1;
                    for (int i = N - 1; i >= 0; i--) if (elig[i]) m_id = i;
                end
            end else if (m_phase == 1) begin
                if (claim) m_phase = 2;
                else if (!elig[m_id]) m_phase = 0;
            end else begin
                if (complete) m_phase = 0;
            end
            m_prev = s;
            m_line.push_front(src);
            void'(m_line.pop_back());
            m_pend = nxt;
        end
        e.irq  = (m_phase == 1);
        e.id   = IDW'(m_id);
        e.busy = (m_phase == 2);
        e.pend = m_pend;
        exp_q.push_back(e);
    endfunction

    // Called half a cycle before a rising edge; returns just after the following falling edge.
    task automatic step();
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {irq, id, busy, pend};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL scoreboard actual irq=%0b id=%0d busy=%0b pend=%b required irq=%0b id=%0d busy=%0b pend=%b @%0t",
                             a.irq, a.id, a.busy, a.pend, e.irq, e.id, e.busy, e.pend, $time);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1; src = '0; emode = '1; mask = '1; claim = 1'b0; complete = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {irq, id, busy, pend}, 0);
        rst = 1'b0;

        // Edge source 1, 3-cycle pulse: present after edge 4.
        src = 3'b010;
        step(); step(); step();
        chk("t1_irq_low_edge3", irq, 0);
        chk("t1_pend_edge3", pend, 3'b010);
        src = 3'b000;
        step();
        chk("t1_irq_edge4", irq, 1);
        chk("t1_id_edge4", id, 1);
        claim = 1'b1; step(); claim = 1'b0;
        chk("t1_pend_claimed", pend, 0);
        chk("t1_busy_claimed", busy, 1);
        complete = 1'b1; step(); complete = 1'b0;
        chk("t1_busy_done", busy, 0);
        chk("t1_irq_done", irq, 0);

        // Masked edge stays pending, unmask raises irq.
        mask = 3'b000;
        src = 3'b001; step(); step(); src = 3'b000;
        repeat (4) step();
        chk("t4_irq_masked", irq, 0);
        chk("t4_pend_masked", pend, 3'b001);
        mask = 3'b001;
        step(); step();
        chk("t4_irq_unmasked", irq, 1);
        chk("t4_id_unmasked", id, 0);
        claim = 1'b1; step(); claim = 1'b0;
        complete = 1'b1; step(); complete = 1'b0;

        // Reset during service, held-high edge source re-presented at edge SS+2.
        mask = 3'b111;
        src = 3'b001;
        for (int k = 0; k < 20 && !irq; k++) step();
        chk("t6_irq_up", irq, 1);
        claim = 1'b1; step(); claim = 1'b0;
        chk("t6_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_async_reset", {irq, id, busy, pend}, 0);
        step();
        rst = 1'b0;
        repeat (SS + 1) step();
        chk("t6_irq_low_before", irq, 0);
        step();
        chk("t6_irq_represent", irq, 1);
        chk("t6_id_represent", id, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) src[i] = ~src[i];
            if ($urandom_range(0, 99) == 0) emode = N'($urandom);
            if ($urandom_range(0, 29) == 0) mask = ($urandom_range(0, 1) == 0) ? N'($urandom) : '1;
            claim    = ($urandom_range(0, 2) == 0);
            complete = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; claim = 1'b0; complete = 1'b0;

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
